mem_ctrl: RTL and testbench
===========================

Name: mem_ctrl

Overview:
- Byte-serial memory controller and arbiter for the single 8-bit RAM/IO bus.
- It shares the bus between instruction fetch (4-byte reads) and the load/store buffer (1/2/4-byte reads and writes).
- It sequences multi-byte accesses, handles the 1-cycle read latency, applies UART back-pressure and honours ROB flush.
- Sits between the fetcher/instruction queue, the load/store buffer, and the cpu top-level mem_* pins.

Parameters:
ADDR_W, 32, width of address buses
IO_MASK, 2'b11, value of addr[17:16] that selects the IO region

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
rdy  in  1  pause when low
flush  in  1  ROB exception/mispredict; aborts fetches and loads
if_req  in  1  fetch request, held until if_done
if_addr  in  32  fetch byte address
if_done  out  1  one-cycle pulse, if_data valid
if_data  out  32  fetched word, little-endian
ls_req  in  1  load/store request, held until ls_done
ls_wr  in  1  1 = store
ls_size  in  2  0 = byte, 1 = half, 2 = word (3 treated as word)
ls_addr  in  32  byte address, no alignment required
ls_wdata  in  32  store data, low bytes used
ls_done  out  1  one-cycle pulse
ls_rdata  out  32  load data, zero-extended (sign-extension is the LSB's job)
mem_din  in  8  RAM read byte
mem_dout  out  8  RAM write byte
mem_a  out  32  RAM address
mem_wr  out  1  1 = write
io_buffer_full  in  1  UART tx buffer full

Behaviour:
- Reset: state IDLE. All outputs 0. Byte counter 0. Round-robin pointer set to ls.
- States:
  - IDLE: in this state, with no request active, mem_a=0, mem_wr=0.
  - READ.
  - WRITE.
- Grant: evaluated at the clock edge in IDLE.
  - ls_req wins over if_req (fixed priority).
  - A requester's req is ignored in the cycle its own done is high.
  - The grant latches addr, size, byte count N (1/2/4; fetch N=4) and wdata.
- Cycle numbering: cycle 1 is the first cycle after the grant edge.
- READ:
  - Cycles 1..N: mem_a = addr+k for k = 0..N-1.
  - mem_din in cycle k+2 holds byte k and is captured into bits [8k+7:8k].
  - Bytes not read are 0.
  - Cycle N+1: mem_a=0.
  - Cycle N+2: done pulses with data; state is IDLE.
  - Word read: done in cycle 6. Byte read: done in cycle 3.
- WRITE:
  - Cycles 1..N: mem_wr=1, mem_a=addr+k, mem_dout=wdata[8k+7:8k].
  - Cycle N+1: ls_done pulses; state is IDLE.
- IO back-pressure: for a write where addr[17:16]==IO_MASK and io_buffer_full=1:
  - Hold the current byte with mem_wr=0, mem_a held.
  - Resume the cycle after io_buffer_full falls.
  - No byte is dropped or duplicated.
- Back-to-back: a request sampled at the end of the done cycle starts its cycle 1 immediately; there is no idle bubble.
- Address arithmetic: addr+k wraps modulo 2^32.
- flush=1 at an edge:
  - An active fetch or load aborts. State goes to IDLE, mem_a=0. No done pulse is produced for it, and its partial data is discarded.
  - An active store always completes, including its ls_done.
  - In IDLE, fetches and loads are not granted at that edge; a store may be granted.
- rdy=0:
  - All registers hold, and mem_wr is forced to 0 combinationally.
  - A read byte issued in a cycle with rdy=0 is reissued; capture happens only for bytes whose address cycle had rdy=1.
  - Done pulses are never generated while rdy=0.
- Simultaneous if_req and ls_req: ls is granted; if_req stays pending and is granted after ls_done.
- rst mid-operation: immediate return to the reset state; the in-flight access is lost and no done pulse is produced.

Optional Feature:
- Macro: MEM_CTRL_RR_ARB_EN.
- Defined: round-robin arbitration.
  - When both if_req and ls_req are pending at a grant edge, the requester not served last wins.
  - The pointer updates on each grant.
  - Flush suppression of fetch grants still applies.
- Undefined: fixed priority, ls over if, with no pointer register.

Test Plan:
- Fetch: mem bytes 0x13,0x05,0x10,0x00 at 0x100; if_req with if_addr=0x100 -> mem_a = 0x100..0x103 in cycles 1-4; if_done in cycle 6; if_data=0x00100513.
- Store half: ls_wr=1, size=1, addr=0x2001, wdata=0xDEADBEEF -> cycles 1-2 show (0x2001,0xEF) and (0x2002,0xBE) with mem_wr=1; ls_done in cycle 3.
- IO stall: store byte 0x41 to 0x30000 with io_buffer_full=1 for 3 cycles -> mem_wr=0 for those cycles; then exactly one write of 0x41; ls_done the next cycle.
- Contention: if_req and ls_req (load byte at 0x10, mem=0x80) raised together -> ls_rdata=0x00000080 in cycle 3; fetch cycle 1 in cycle 4. With MEM_CTRL_RR_ARB_EN and a second simultaneous pair -> fetch is granted first.
- Flush: flush in cycle 2 of a word fetch -> no if_done; mem_a=0 from the next cycle. Flush during a word store -> all 4 writes occur and ls_done pulses.
- Pause: rdy=0 during cycle 2 of a byte load of 0x55 -> ls_done is delayed by one cycle; ls_rdata=0x55; mem_wr stays 0.

Source files
------------

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: bundle of the fetch port, the load/store port and the
// byte-wide RAM/IO bus that the memory controller arbitrates.
//   slave  modport: the controller side (takes requests, drives the RAM bus).
//   master modport: the requesters plus RAM model side.
// Parameter ADDR_W sets the width of all address fields (>= 18).
interface mem_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_done;
    logic [31:0]       if_data;

    logic              ls_req;
    logic              ls_wr;
    logic [1:0]        ls_size;
    logic [ADDR_W-1:0] ls_addr;
    logic [31:0]       ls_wdata;
    logic              ls_done;
    logic [31:0]       ls_rdata;

    logic [7:0]        mem_din;
    logic [7:0]        mem_dout;
    logic [ADDR_W-1:0] mem_a;
    logic              mem_wr;
    logic              io_buffer_full;

    modport slave (
        input  if_req, if_addr, ls_req, ls_wr, ls_size, ls_addr, ls_wdata,
        input  mem_din, io_buffer_full,
        output if_done, if_data, ls_done, ls_rdata,
        output mem_dout, mem_a, mem_wr
    );

    modport master (
        output if_req, if_addr, ls_req, ls_wr, ls_size, ls_addr, ls_wdata,
        output mem_din, io_buffer_full,
        input  if_done, if_data, ls_done, ls_rdata,
        input  mem_dout, mem_a, mem_wr
    );
endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial memory controller / arbiter for the shared 8-bit
// RAM/IO bus. Serves 4-byte instruction fetches and 1/2/4-byte loads and
// stores, one byte per cycle, with a 1-cycle RAM read latency.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   rdy        : global pause (registers hold, mem_wr forced low)
//   flush      : aborts in-flight fetches/loads, blocks their grants
//   bus        : mem_ctrl_if.slave (fetch port, load/store port, RAM bus,
//                io_buffer_full)
// Build option: define MEM_CTRL_RR_ARB_EN for round-robin arbitration between
// fetch and load/store; otherwise load/store has fixed priority.
module mem_ctrl #(
    parameter int         ADDR_W  = 32,
    parameter logic [1:0] IO_MASK = 2'b11
) (
    input logic        clk,
    input logic        rst,
    input logic        rdy,
    input logic        flush,
    mem_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    // Byte k of a little-endian word.
    function automatic logic [7:0] byte_sel(input logic [31:0] w, input logic [1:0] k);
        case (k)
            2'd0:    return w[7:0];
            2'd1:    return w[15:8];
            2'd2:    return w[23:16];
            default: return w[31:24];
        endcase
    endfunction

    // Index of the last byte of an access of the given size (size 3 = word).
    function automatic logic [1:0] size_to_last(input logic [1:0] size);
        case (size)
            2'd0:    return 2'd0;
            2'd1:    return 2'd1;
            default: return 2'd3;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        last_q, last_d;
    logic [1:0]        idx_q, idx_d;
    logic              issue_q, issue_d;      // mem_a_q carries a read address
    logic              cap_vld_q, cap_vld_d;  // mem_din holds a byte to capture
    logic [1:0]        cap_idx_q, cap_idx_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       data_q, data_d;
    logic              is_if_q, is_if_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              mem_wr_q, mem_wr_d;
    logic              if_done_q, if_done_d;
    logic [31:0]       if_data_q, if_data_d;
    logic              ls_done_q, ls_done_d;
    logic [31:0]       ls_rdata_q, ls_rdata_d;
`ifdef MEM_CTRL_RR_ARB_EN
    logic              last_ls_q, last_ls_d;  // 1 = load/store was served last
`endif

    logic              if_ok_s, ls_ok_s, grant_if_s, grant_ls_s, stall_s;
    logic [31:0]       cap_data_s;
    logic [1:0]        idx_nx_s;
    logic [ADDR_W-1:0] addr_nx_s;

    // Eligibility: a requester is ignored while its own done is showing, and
    // flush blocks fetches and loads but not stores.
    assign if_ok_s   = bus.if_req & ~if_done_q & ~flush;
    assign ls_ok_s   = bus.ls_req & ~ls_done_q & (~flush | bus.ls_wr);
    // The current write byte stalls while it targets the IO region and the
    // UART cannot accept it.
    assign stall_s   = (mem_a_q[17:16] == IO_MASK) & bus.io_buffer_full;
    assign idx_nx_s  = idx_q + 2'd1;
    assign addr_nx_s = addr_q + ADDR_W'(idx_nx_s);

    // Arbitration between the two requesters.
    always_comb begin
`ifdef MEM_CTRL_RR_ARB_EN
        if (if_ok_s && ls_ok_s) begin
            grant_if_s = last_ls_q;
            grant_ls_s = ~last_ls_q;
        end else begin
            grant_if_s = if_ok_s;
            grant_ls_s = ls_ok_s;
        end
`else
        grant_ls_s = ls_ok_s;
        grant_if_s = if_ok_s & ~ls_ok_s;
`endif
    end

    // Merge the byte arriving on mem_din into the read accumulator. This
    // happens even when rdy is low, because the byte's address was accepted.
    always_comb begin
        cap_data_s = data_q;
        if (cap_vld_q) begin
            case (cap_idx_q)
                2'd0:    cap_data_s[7:0]   = bus.mem_din;
                2'd1:    cap_data_s[15:8]  = bus.mem_din;
                2'd2:    cap_data_s[23:16] = bus.mem_din;
                default: cap_data_s[31:24] = bus.mem_din;
            endcase
        end else begin
            cap_data_s = data_q;
        end
    end

    // Next-state and next-output logic of the access sequencer.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        last_d     = last_q;
        idx_d      = idx_q;
        issue_d    = issue_q;
        cap_vld_d  = cap_vld_q;
        cap_idx_d  = cap_idx_q;
        wdata_d    = wdata_q;
        data_d     = cap_data_s;
        is_if_d    = is_if_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        mem_wr_d   = mem_wr_q;
        if_done_d  = 1'b0;
        if_data_d  = if_data_q;
        ls_done_d  = 1'b0;
        ls_rdata_d = ls_rdata_q;
`ifdef MEM_CTRL_RR_ARB_EN
        last_ls_d  = last_ls_q;
`endif
        case (state_q)
            IDLE: begin
                if (rdy && (grant_if_s || grant_ls_s)) begin
                    is_if_d   = grant_if_s;
                    idx_d     = 2'd0;
                    data_d    = 32'd0;
                    cap_vld_d = 1'b0;
                    wdata_d   = bus.ls_wdata;
                    if (grant_if_s) begin
                        addr_d  = bus.if_addr;
                        last_d  = 2'd3;
                        mem_a_d = bus.if_addr;
                    end else begin
                        addr_d  = bus.ls_addr;
                        last_d  = size_to_last(bus.ls_size);
                        mem_a_d = bus.ls_addr;
                    end
                    if (grant_ls_s && bus.ls_wr) begin
                        state_d    = WRITE;
                        issue_d    = 1'b0;
                        mem_wr_d   = 1'b1;
                        mem_dout_d = bus.ls_wdata[7:0];
                    end else begin
                        state_d  = READ;
                        issue_d  = 1'b1;
                        mem_wr_d = 1'b0;
                    end
`ifdef MEM_CTRL_RR_ARB_EN
                    last_ls_d = grant_ls_s;
`endif
                end else if (rdy) begin
                    mem_a_d  = '0;
                    mem_wr_d = 1'b0;
                end else begin
                    mem_a_d = mem_a_q;
                end
            end
            READ: begin
                if (!rdy) begin
                    // Address not accepted: it is presented again next cycle.
                    cap_vld_d = 1'b0;
                end else if (flush) begin
                    state_d   = IDLE;
                    mem_a_d   = '0;
                    issue_d   = 1'b0;
                    cap_vld_d = 1'b0;
                end else if (issue_q) begin
                    cap_vld_d = 1'b1;
                    cap_idx_d = idx_q;
                    if (idx_q == last_q) begin
                        issue_d = 1'b0;
                        mem_a_d = '0;
                    end else begin
                        idx_d   = idx_nx_s;
                        mem_a_d = addr_nx_s;
                    end
                end else begin
                    // All addresses accepted; the last byte lands this edge.
                    state_d   = IDLE;
                    mem_a_d   = '0;
                    cap_vld_d = 1'b0;
                    if (is_if_q) begin
                        if_done_d = 1'b1;
                        if_data_d = cap_data_s;
                    end else begin
                        ls_done_d  = 1'b1;
                        ls_rdata_d = cap_data_s;
                    end
                end
            end
            WRITE: begin
                if (rdy && !stall_s) begin
                    if (idx_q == last_q) begin
                        state_d    = IDLE;
                        mem_a_d    = '0;
                        mem_wr_d   = 1'b0;
                        mem_dout_d = 8'd0;
                        ls_done_d  = 1'b1;
                    end else begin
                        idx_d      = idx_nx_s;
                        mem_a_d    = addr_nx_s;
                        mem_dout_d = byte_sel(wdata_q, idx_nx_s);
                    end
                end else begin
                    idx_d = idx_q;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_a_d   = '0;
                mem_wr_d  = 1'b0;
                issue_d   = 1'b0;
                cap_vld_d = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            last_q     <= 2'd0;
            idx_q      <= 2'd0;
            issue_q    <= 1'b0;
            cap_vld_q  <= 1'b0;
            cap_idx_q  <= 2'd0;
            wdata_q    <= 32'd0;
            data_q     <= 32'd0;
            is_if_q    <= 1'b0;
            mem_a_q    <= '0;
            mem_dout_q <= 8'd0;
            mem_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            if_data_q  <= 32'd0;
            ls_done_q  <= 1'b0;
            ls_rdata_q <= 32'd0;
`ifdef MEM_CTRL_RR_ARB_EN
            last_ls_q  <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            last_q     <= last_d;
            idx_q      <= idx_d;
            issue_q    <= issue_d;
            cap_vld_q  <= cap_vld_d;
            cap_idx_q  <= cap_idx_d;
            wdata_q    <= wdata_d;
            data_q     <= data_d;
            is_if_q    <= is_if_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            mem_wr_q   <= mem_wr_d;
            if_done_q  <= if_done_d;
            if_data_q  <= if_data_d;
            ls_done_q  <= ls_done_d;
            ls_rdata_q <= ls_rdata_d;
`ifdef MEM_CTRL_RR_ARB_EN
            last_ls_q  <= last_ls_d;
`endif
        end
    end

    assign bus.mem_a    = mem_a_q;
    assign bus.mem_dout = mem_dout_q;
    // rdy and the UART stall gate the strobe directly so no byte is written
    // in a cycle where it would be lost.
    assign bus.mem_wr   = mem_wr_q & rdy & ~stall_s;
    assign bus.if_done  = if_done_q;
    assign bus.if_data  = if_data_q;
    assign bus.ls_done  = ls_done_q;
    assign bus.ls_rdata = ls_rdata_q;
endmodule

// File: tb/tb_mem_ctrl.sv
// Testbench for mem_ctrl: RAM model on the byte bus, directed stimulus that
// pushes expected done events into a scoreboard queue, and a monitor that pops
// and compares whenever a done pulse appears. Bus activity is checked per cycle.
module tb_mem_ctrl;
    logic clk = 1'b0;
    logic rst, rdy, flush;
    always #5 clk = ~clk;

    mem_ctrl_if #(.ADDR_W(32)) bus ();

    mem_ctrl #(.ADDR_W(32), .IO_MASK(2'b11)) dut (
        .clk   (clk),
        .rst   (rst),
        .rdy   (rdy),
        .flush (flush),
        .bus   (bus)
    );

    typedef struct {
        int          kind;      // 0 = fetch, 1 = load/store
        logic [31:0] data;
        int          cyc;
        bit          chk_data;
    } exp_t;

    exp_t        exp_q[$];
    logic [7:0]  ram [0:65535];
    int          io_writes = 0;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;
    int          c0;

    always @(posedge clk) cyc <= cyc + 1;

    // RAM: registered read of the presented address, write on mem_wr.
    always @(posedge clk) begin
        bus.mem_din <= ram[bus.mem_a[15:0]];
        if (bus.mem_wr) begin
            ram[bus.mem_a[15:0]] = bus.mem_dout;
            if (bus.mem_a == 32'h0003_0000) io_writes = io_writes + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the next scoreboard entry.
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] d;
        int          k;
        if (!rst && (bus.if_done || bus.ls_done)) begin
            k = bus.ls_done ? 1 : 0;
            d = bus.ls_done ? bus.ls_rdata : bus.if_data;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: kind=%0d data=0x%08h cycle=%0d nothing pending", k, d, cyc);
            end else begin
                e = exp_q.pop_front();
                chk("done_kind", k, e.kind);
                chk("done_cycle", cyc, e.cyc);
                if (e.chk_data) chk("done_data", d, e.data);
            end
        end
    end

    // Advance to just after the next rising edge; requesters drop on done.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        if (bus.if_done) bus.if_req = 1'b0;
        if (bus.ls_done) bus.ls_req = 1'b0;
    endtask

    // Mid-cycle check of the RAM bus.
    task automatic cyc_chk(input string tag, input logic [31:0] a, input logic wr);
        #3;
        chk({tag, "_mem_a"}, bus.mem_a, a);
        chk({tag, "_mem_wr"}, {31'd0, bus.mem_wr}, {31'd0, wr});
    endtask

    task automatic push(input int kind, input logic [31:0] data, input int at, input bit cd);
        exp_t e;
        e.kind = kind; e.data = data; e.cyc = at; e.chk_data = cd;
        exp_q.push_back(e);
    endtask

    task automatic ls_start(input logic wr, input logic [1:0] size, input logic [31:0] a,
                            input logic [31:0] wd);
        bus.ls_req = 1'b1; bus.ls_wr = wr; bus.ls_size = size;
        bus.ls_addr = a; bus.ls_wdata = wd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] = 8'h00;
        ram[16'h0100] = 8'h13; ram[16'h0101] = 8'h05; ram[16'h0102] = 8'h10; ram[16'h0103] = 8'h00;
        ram[16'h0010] = 8'h80;
        ram[16'h0200] = 8'h11; ram[16'h0201] = 8'h22; ram[16'h0202] = 8'h33; ram[16'h0203] = 8'h44;
        ram[16'h0040] = 8'h55;
        rst = 1'b1; rdy = 1'b1; flush = 1'b0;
        bus.if_req = 1'b0; bus.if_addr = 32'd0; bus.ls_req = 1'b0; bus.ls_wr = 1'b0;
        bus.ls_size = 2'd0; bus.ls_addr = 32'd0; bus.ls_wdata = 32'd0; bus.io_buffer_full = 1'b0;
        repeat (3) @(posedge clk);
        #4;
        chk("rst_mem_a", bus.mem_a, 32'd0);
        chk("rst_mem_wr", {31'd0, bus.mem_wr}, 32'd0);
        chk("rst_mem_dout", {24'd0, bus.mem_dout}, 32'd0);
        chk("rst_done", {30'd0, bus.if_done, bus.ls_done}, 32'd0);
        chk("rst_if_data", bus.if_data, 32'd0);
        chk("rst_ls_rdata", bus.ls_rdata, 32'd0);
        next_cycle(); rst = 1'b0;
        next_cycle();

        // Word fetch at 0x100: bytes 0x100..0x103 in cycles 1-4, done cycle 6.
        c0 = cyc; bus.if_req = 1'b1; bus.if_addr = 32'h100;
        push(0, 32'h0010_0513, c0 + 6, 1'b1);
        for (int k = 1; k <= 6; k++) begin
            next_cycle();
            cyc_chk("fetch", (k <= 4) ? 32'h100 + 32'(k - 1) : 32'd0, 1'b0);
        end

        // Half store 0xDEADBEEF at 0x2001.
        next_cycle(); c0 = cyc; ls_start(1'b1, 2'd1, 32'h2001, 32'hDEAD_BEEF);
        push(1, 32'd0, c0 + 3, 1'b0);
        next_cycle(); cyc_chk("sth1", 32'h2001, 1'b1); chk("sth1_dout", {24'd0, bus.mem_dout}, 32'hEF);
        next_cycle(); cyc_chk("sth2", 32'h2002, 1'b1); chk("sth2_dout", {24'd0, bus.mem_dout}, 32'hBE);
        next_cycle(); cyc_chk("sth3", 32'd0, 1'b0);

        // Unaligned half load from 0x2001 reads back the store, zero-extended.
        next_cycle(); c0 = cyc; ls_start(1'b0, 2'd1, 32'h2001, 32'd0);
        push(1, 32'h0000_BEEF, c0 + 4, 1'b1);
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            cyc_chk("ldh", (k <= 2) ? 32'h2001 + 32'(k - 1) : 32'd0, 1'b0);
        end

        // IO store stalled by a full UART buffer for cycles 1-3.
        next_cycle(); c0 = cyc; bus.io_buffer_full = 1'b1; ls_start(1'b1, 2'd0, 32'h3_0000, 32'h41);
        push(1, 32'd0, c0 + 5, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            next_cycle(); cyc_chk("io_stall", 32'h3_0000, 1'b0);
        end
        next_cycle(); bus.io_buffer_full = 1'b0;
        cyc_chk("io_wr", 32'h3_0000, 1'b1); chk("io_dout", {24'd0, bus.mem_dout}, 32'h41);
        next_cycle(); cyc_chk("io_end", 32'd0, 1'b0);
        chk("io_write_count", io_writes, 32'd1);

        // Contention: load byte wins, fetch starts the cycle after ls_done.
        next_cycle(); c0 = cyc;
        bus.if_req = 1'b1; bus.if_addr = 32'h200; ls_start(1'b0, 2'd0, 32'h10, 32'd0);
        push(1, 32'h0000_0080, c0 + 3, 1'b1);
        push(0, 32'h4433_2211, c0 + 9, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            next_cycle();
            cyc_chk("contend", (k == 1) ? 32'h10 :
                               (k >= 4 && k <= 7) ? 32'h200 + 32'(k - 4) : 32'd0, 1'b0);
        end

        // Flush in cycle 2 of a word fetch: no if_done, bus idle from cycle 3.
        next_cycle(); c0 = cyc; bus.if_req = 1'b1; bus.if_addr = 32'h100;
        next_cycle(); cyc_chk("flf1", 32'h100, 1'b0);
        next_cycle(); flush = 1'b1; cyc_chk("flf2", 32'h101, 1'b0);
        next_cycle(); flush = 1'b0; bus.if_req = 1'b0; cyc_chk("flf3", 32'd0, 1'b0);
        for (int k = 4; k <= 7; k++) begin
            next_cycle(); cyc_chk("flf_idle", 32'd0, 1'b0);
        end

        // Word store granted and carried through a flush.
        next_cycle(); c0 = cyc; flush = 1'b1; ls_start(1'b1, 2'd2, 32'h3000, 32'h0403_0201);
        push(1, 32'd0, c0 + 5, 1'b0);
        for (int k = 1; k <= 4; k++) begin
            next_cycle();
            if (k == 3) flush = 1'b0;
            cyc_chk("flst", 32'h3000 + 32'(k - 1), 1'b1);
            chk("flst_dout", {24'd0, bus.mem_dout}, 32'(k));
        end
        next_cycle(); cyc_chk("flst_end", 32'd0, 1'b0);

        // Word load confirms all four stored bytes.
        next_cycle(); c0 = cyc; ls_start(1'b0, 2'd2, 32'h3000, 32'd0);
        push(1, 32'h0403_0201, c0 + 6, 1'b1);
        repeat (6) next_cycle();

        // Pause during cycle 2 of a byte load delays ls_done by one cycle.
        next_cycle(); c0 = cyc; ls_start(1'b0, 2'd0, 32'h40, 32'd0);
        push(1, 32'h0000_0055, c0 + 4, 1'b1);
        next_cycle(); cyc_chk("pause1", 32'h40, 1'b0);
        next_cycle(); rdy = 1'b0; cyc_chk("pause2", 32'd0, 1'b0);
        next_cycle(); rdy = 1'b1; cyc_chk("pause3", 32'd0, 1'b0);
        next_cycle(); cyc_chk("pause4", 32'd0, 1'b0);

        // Size 3 load at 0xFFFFFFFF: address wraps to 0.
        ram[16'hFFFF] = 8'hA1; ram[16'h0000] = 8'hB2; ram[16'h0001] = 8'hC3; ram[16'h0002] = 8'hD4;
        next_cycle(); c0 = cyc; ls_start(1'b0, 2'd3, 32'hFFFF_FFFF, 32'd0);
        push(1, 32'hD4C3_B2A1, c0 + 6, 1'b1);
        next_cycle(); cyc_chk("wrap1", 32'hFFFF_FFFF, 1'b0);
        for (int k = 2; k <= 6; k++) begin
            next_cycle(); cyc_chk("wrap", (k <= 4) ? 32'(k - 2) : 32'd0, 1'b0);
        end

        // Reset in cycle 2 of a fetch: access lost, no done.
        next_cycle(); c0 = cyc; bus.if_req = 1'b1; bus.if_addr = 32'h100;
        next_cycle(); cyc_chk("rstm1", 32'h100, 1'b0);
        next_cycle(); rst = 1'b1;
        next_cycle(); rst = 1'b0; bus.if_req = 1'b0; cyc_chk("rstm3", 32'd0, 1'b0);
        for (int k = 4; k <= 8; k++) begin
            next_cycle(); cyc_chk("rstm_idle", 32'd0, 1'b0);
        end

        repeat (3) next_cycle();
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
